// File: rtl/qspi_pkg.sv
// Shared QSPI receive-path definitions.
// Lane count, word width, FSM states and size normalisation.
package qspi_pkg;

    localparam int unsigned QSPI_LANES    = 4;
    localparam int unsigned QSPI_MAX_BITS = 40;

    typedef enum logic [0:0] {
        RX_IDLE,
        RX_SHIFT
    } rx_state_e;

    // Round down to whole nibbles and clamp to the word width.
    function automatic logic [5:0] qspi_norm_size(input logic [5:0] rsize);
        logic [5:0] s;
        s = {rsize[5:2], 2'b00};
        if (s > 6'(QSPI_MAX_BITS)) begin
            s = 6'(QSPI_MAX_BITS);
        end
        return s;
    endfunction

endpackage

// File: rtl/qspi_rx_obuf.sv
// Receive output buffer: holds one word behind a valid/ready
// handshake and flags words overwritten before being consumed.
module qspi_rx_obuf
    import qspi_pkg::*;
#(
    parameter int unsigned DataWidth = QSPI_MAX_BITS
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 load_i,
    input  logic [DataWidth-1:0] data_i,
    input  logic                 rready_i,
    input  logic                 clr_ovr_i,
    output logic [DataWidth-1:0] rdata_o,
    output logic                 rvalid_o,
    output logic                 overrun_o
);

    logic [DataWidth-1:0] rdata_d, rdata_q;
    logic                 rvalid_d, rvalid_q;
    logic                 ovr_d, ovr_q;
    logic                 ovr_set;

    // Next-state for the holding register, valid flag and overrun flag.
    always_comb begin
        rdata_d  = rdata_q;
        rvalid_d = rvalid_q;
        ovr_d    = ovr_q;
        ovr_set  = load_i && rvalid_q && !rready_i;
        if (load_i) begin
            rdata_d  = data_i;
            rvalid_d = 1'b1;
        end else if (rvalid_q && rready_i) begin
            rvalid_d = 1'b0;
        end
        if (ovr_set) begin
            ovr_d = 1'b1;
        end else if (clr_ovr_i) begin
            ovr_d = 1'b0;
        end
    end

    // Buffer state registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            ovr_q    <= 1'b0;
        end else begin
            rdata_q  <= rdata_d;
            rvalid_q <= rvalid_d;
            ovr_q    <= ovr_d;
        end
    end

    assign rdata_o   = rdata_q;
    assign rvalid_o  = rvalid_q;
    assign overrun_o = ovr_q;

endmodule

// File: rtl/qspi_rshift.sv
// Quad receive shifter: assembles lane nibbles into a word,
// LSB- or MSB-first, and hands it to the output buffer.
module qspi_rshift
    import qspi_pkg::*;
#(
    parameter int unsigned DataWidth = QSPI_MAX_BITS,
    parameter int unsigned Lanes     = QSPI_LANES
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 start_i,
    input  logic [5:0]           rsize_i,
    input  logic                 msb_first_i,
    input  logic                 sample_en_i,
    input  logic [Lanes-1:0]     sdi_i,
    input  logic                 abort_i,
    output logic [DataWidth-1:0] rdata_o,
    output logic                 rvalid_o,
    input  logic                 rready_i,
    output logic                 busy_o,
    output logic [5:0]           bit_index_o,
    output logic                 r_intr_o,
    output logic                 overrun_o,
    input  logic                 clr_ovr_i
);

    localparam logic [DataWidth-1:0] NibMask =
        {{(DataWidth-Lanes){1'b0}}, {Lanes{1'b1}}};

    rx_state_e            state_d, state_q;
    logic [5:0]           size_d, size_q;
    logic                 msb_d, msb_q;
    logic [5:0]           bi_d, bi_q;
    logic [DataWidth-1:0] sreg_d, sreg_q;
    logic                 intr_d, intr_q;
    logic                 load;
    logic [5:0]           norm;
    logic [5:0]           base;
    logic [DataWidth-1:0] nib;

    assign norm = qspi_norm_size(rsize_i);
    assign base = msb_q ? (size_q - 6'd4 - bi_q) : bi_q;
    assign nib  = {{(DataWidth-Lanes){1'b0}}, sdi_i};

    // FSM, shift-register placement and bit counter next-state.
    always_comb begin
        state_d = state_q;
        size_d  = size_q;
        msb_d   = msb_q;
        bi_d    = bi_q;
        sreg_d  = sreg_q;
        load    = 1'b0;
        unique case (state_q)
            RX_IDLE: begin
                if (start_i && norm != 6'd0) begin
                    state_d = RX_SHIFT;
                    size_d  = norm;
                    msb_d   = msb_first_i;
                    bi_d    = '0;
                    sreg_d  = '0;
                end
            end
            RX_SHIFT: begin
                if (abort_i) begin
                    state_d = RX_IDLE;
                    bi_d    = '0;
                    sreg_d  = '0;
                end else if (sample_en_i) begin
                    sreg_d = (sreg_q & ~(NibMask << base))
                           | (nib << base);
                    if (bi_q + 6'd4 == size_q) begin
                        load    = 1'b1;
                        state_d = RX_IDLE;
                        bi_d    = '0;
                    end else begin
                        bi_d = bi_q + 6'd4;
                    end
                end
            end
            default: state_d = RX_IDLE;
        endcase
        intr_d = load;
    end

    // Control and shift registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= RX_IDLE;
            size_q  <= '0;
            msb_q   <= 1'b0;
            bi_q    <= '0;
            sreg_q  <= '0;
            intr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            size_q  <= size_d;
            msb_q   <= msb_d;
            bi_q    <= bi_d;
            sreg_q  <= sreg_d;
            intr_q  <= intr_d;
        end
    end

    qspi_rx_obuf #(
        .DataWidth (DataWidth)
    ) u_obuf (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .load_i    (load),
        .data_i    (sreg_d),
        .rready_i  (rready_i),
        .clr_ovr_i (clr_ovr_i),
        .rdata_o   (rdata_o),
        .rvalid_o  (rvalid_o),
        .overrun_o (overrun_o)
    );

    assign busy_o      = (state_q == RX_SHIFT);
    assign bit_index_o = bi_q;
    assign r_intr_o    = intr_q;

endmodule

// File: tb/tb_qspi_rshift.sv
// Directed bench for the quad receive shifter.
// Hand-computed expected words for each scenario.
module tb_qspi_rshift;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        start_i = 1'b0;
    logic [5:0]  rsize_i = '0;
    logic        msb_first_i = 1'b0;
    logic        sample_en_i = 1'b0;
    logic [3:0]  sdi_i = '0;
    logic        abort_i = 1'b0;
    logic [39:0] rdata_o;
    logic        rvalid_o;
    logic        rready_i = 1'b0;
    logic        busy_o;
    logic [5:0]  bit_index_o;
    logic        r_intr_o;
    logic        overrun_o;
    logic        clr_ovr_i = 1'b0;

    int n_cmp = 0;
    int n_bad = 0;

    qspi_rshift dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .start_i     (start_i),
        .rsize_i     (rsize_i),
        .msb_first_i (msb_first_i),
        .sample_en_i (sample_en_i),
        .sdi_i       (sdi_i),
        .abort_i     (abort_i),
        .rdata_o     (rdata_o),
        .rvalid_o    (rvalid_o),
        .rready_i    (rready_i),
        .busy_o      (busy_o),
        .bit_index_o (bit_index_o),
        .r_intr_o    (r_intr_o),
        .overrun_o   (overrun_o),
        .clr_ovr_i   (clr_ovr_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_start(input logic [5:0] sz, input logic msb);
        start_i     = 1'b1;
        rsize_i     = sz;
        msb_first_i = msb;
        tick();
        start_i = 1'b0;
    endtask

    task automatic strobe(input logic [3:0] v);
        sample_en_i = 1'b1;
        sdi_i       = v;
        tick();
        sample_en_i = 1'b0;
        sdi_i       = '0;
    endtask

    task automatic accept();
        rready_i = 1'b1;
        tick();
        rready_i = 1'b0;
    endtask

    initial begin
        #12;
        check("rst_rdata", rdata_o, 0);
        check("rst_rvalid", rvalid_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_bidx", bit_index_o, 0);
        check("rst_intr", r_intr_o, 0);
        check("rst_ovr", overrun_o, 0);
        rst_ni = 1'b1;
        tick();

        // LSB-first 8 bits: A then 5
        do_start(6'd8, 1'b0);
        check("t1_busy", busy_o, 1);
        strobe(4'hA);
        check("t1_bidx4", bit_index_o, 4);
        check("t1_nvalid", rvalid_o, 0);
        strobe(4'h5);
        check("t1_rvalid", rvalid_o, 1);
        check("t1_intr", r_intr_o, 1);
        check("t1_busy0", busy_o, 0);
        check("t1_bidx0", bit_index_o, 0);
        check("t1_rdata", rdata_o, 40'h000000005A);
        tick();
        check("t1_intr_1cyc", r_intr_o, 0);
        check("t1_hold", rvalid_o, 1);
        accept();
        check("t1_cleared", rvalid_o, 0);

        // MSB-first 16 bits with gaps; start during SHIFT ignored
        do_start(6'd16, 1'b1);
        check("t2_bidx_s", bit_index_o, 0);
        strobe(4'h1);
        check("t2_bidx4", bit_index_o, 4);
        tick(); tick();
        check("t2_gap_hold", bit_index_o, 4);
        do_start(6'd4, 1'b0);
        check("t2_restart_ign", bit_index_o, 4);
        strobe(4'h2);
        check("t2_bidx8", bit_index_o, 8);
        tick(); tick();
        strobe(4'h3);
        check("t2_bidx12", bit_index_o, 12);
        tick(); tick();
        strobe(4'h4);
        check("t2_bidx0", bit_index_o, 0);
        check("t2_rdata", rdata_o, 40'h0000001234);
        check("t2_rvalid", rvalid_o, 1);
        accept();

        // Two 40-bit words with no consumer -> overrun
        do_start(6'd40, 1'b0);
        for (int i = 0; i < 10; i++) strobe(4'(i + 1));
        check("t3_w1", rdata_o, 40'hA987654321);
        check("t3_novr", overrun_o, 0);
        do_start(6'd40, 1'b0);
        for (int i = 0; i < 10; i++) strobe(4'(15 - i));
        check("t3_w2", rdata_o, 40'h6789ABCDEF);
        check("t3_ovr", overrun_o, 1);
        check("t3_valid", rvalid_o, 1);
        clr_ovr_i = 1'b1;
        tick();
        clr_ovr_i = 1'b0;
        check("t3_ovr_clr", overrun_o, 0);
        accept();

        // Abort after 3 strobes of a 32-bit transfer
        do_start(6'd32, 1'b0);
        strobe(4'h1); strobe(4'h2); strobe(4'h3);
        check("t4_bidx12", bit_index_o, 12);
        abort_i = 1'b1;
        tick();
        abort_i = 1'b0;
        check("t4_busy", busy_o, 0);
        check("t4_bidx", bit_index_o, 0);
        check("t4_intr", r_intr_o, 0);
        check("t4_nvalid", rvalid_o, 0);
        do_start(6'd4, 1'b0);
        strobe(4'hF);
        check("t4_rdata", rdata_o, 40'hF);
        check("t4_rvalid", rvalid_o, 1);
        accept();

        // Size rules
        do_start(6'd0, 1'b0);
        check("t5_sz0_busy", busy_o, 0);
        do_start(6'd6, 1'b0);
        strobe(4'h7);
        check("t5_sz6_valid", rvalid_o, 1);
        check("t5_sz6_data", rdata_o, 40'h7);
        accept();
        do_start(6'd63, 1'b0);
        for (int i = 0; i < 9; i++) strobe(4'h3);
        check("t5_sz63_9", rvalid_o, 0);
        check("t5_sz63_busy", busy_o, 1);
        strobe(4'h3);
        check("t5_sz63_10", rvalid_o, 1);
        check("t5_sz63_data", rdata_o, 40'h3333333333);

        // Completion coinciding with acceptance: no overrun
        do_start(6'd4, 1'b0);
        rready_i = 1'b1;
        strobe(4'h9);
        rready_i = 1'b0;
        check("t6_valid", rvalid_o, 1);
        check("t6_data", rdata_o, 40'h9);
        check("t6_novr", overrun_o, 0);

        // Async reset mid-transfer, then a fresh transfer
        do_start(6'd8, 1'b0);
        strobe(4'h1);
        #2;
        rst_ni = 1'b0;
        #1;
        check("t7_rdata", rdata_o, 0);
        check("t7_rvalid", rvalid_o, 0);
        check("t7_busy", busy_o, 0);
        check("t7_bidx", bit_index_o, 0);
        check("t7_intr", r_intr_o, 0);
        check("t7_ovr", overrun_o, 0);
        #1;
        rst_ni = 1'b1;
        tick();
        do_start(6'd8, 1'b0);
        strobe(4'hC);
        strobe(4'h3);
        check("t7_rdata2", rdata_o, 40'h3C);
        check("t7_intr2", r_intr_o, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
